// File: rtl/slot_pkg.sv
// Shared constants, sequencer state encoding and reel helper for the reel spin sequencer.
package slot_pkg;

  localparam int N_SYMBOLS = 8;
  localparam int SYM_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FAST   = 3'd1,
    ST_SLOW_L = 3'd2,
    ST_SLOW_R = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  // A reel has exactly N_SYMBOLS = 2**SYM_W positions, so natural overflow is the wrap.
  function automatic logic [SYM_W-1:0] sym_next(input logic [SYM_W-1:0] sym);
    return sym + SYM_W'(1);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Reel step period counter: one-cycle tick every PERIOD cycles (fast) or 2*PERIOD cycles (slow).
module step_timer #(
  parameter int unsigned PERIOD = 4,
  parameter int unsigned TW     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic slow,
  output logic tick
);

  localparam logic [TW-1:0] FAST_LAST = TW'(PERIOD - 1);
  localparam logic [TW-1:0] SLOW_LAST = TW'(2 * PERIOD - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] last;

  assign last = slow ? SLOW_LAST : FAST_LAST;
  assign tick = run && (cnt_q == last);

  // Holding the count at zero while idle makes every period start at state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reel_spin_sequencer.sv
// Two-reel slot spin sequencer: fast spin, left reel slows and stops, then right reel.
// Optional build macro CHEAT_MODE_EN forces the right target to equal the left target.
module reel_spin_sequencer
  import slot_pkg::*;
#(
  parameter int unsigned STEP_CYC  = 2500000,
  parameter int unsigned MIN_STEPS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic             cheat_mode,
  output logic [SYM_W-1:0] sym_left,
  output logic [SYM_W-1:0] sym_right,
  output logic             busy,
  output logic             done,
  output logic             result_match,
  output logic [2:0]       state_dbg
);

  localparam int CNT_W = ($clog2(MIN_STEPS + 1) > 4) ? $clog2(MIN_STEPS + 1) : 4;
  localparam int TMR_W = $clog2(2 * STEP_CYC);
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_STEPS);
  localparam logic [CNT_W-1:0] SLOW_R_MIN = CNT_W'(N_SYMBOLS);

  // Handshake: start is accepted only on a cycle where busy is low; each accepted
  // start produces exactly one done pulse unless rst aborts the spin.

  seq_state_e       state_q, state_d;
  logic [SYM_W-1:0] left_q, left_d;
  logic [SYM_W-1:0] right_q, right_d;
  logic [SYM_W-1:0] tgt_l_q, tgt_l_d;
  logic [SYM_W-1:0] tgt_r_q, tgt_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             match_q, match_d;

  logic             tick;
  logic             run;
  logic             slow;
  logic [SYM_W-1:0] left_next;
  logic [SYM_W-1:0] right_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_seed_hi;

  assign unused_seed_hi = ^seed[15:6];

`ifndef CHEAT_MODE_EN
  logic unused_cheat;
  assign unused_cheat = cheat_mode;
`endif

  assign run        = (state_q == ST_FAST) || (state_q == ST_SLOW_L) || (state_q == ST_SLOW_R);
  assign slow       = (state_q != ST_FAST);
  assign left_next  = sym_next(left_q);
  assign right_next = sym_next(right_q);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  step_timer #(
    .PERIOD (STEP_CYC),
    .TW     (TMR_W)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .slow (slow),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    match_d = match_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tgt_l_d = seed[2:0];
          tgt_r_d = seed[5:3];
`ifdef CHEAT_MODE_EN
          if (cheat_mode) begin
            tgt_r_d = seed[2:0];
          end
`endif
          cnt_d   = '0;
          match_d = 1'b0;
          state_d = ST_FAST;
        end
      end

      ST_FAST: begin
        if (tick) begin
          left_d  = left_next;
          right_d = right_next;
          if (cnt_inc == MIN_CNT) begin
            cnt_d   = '0;
            state_d = ST_SLOW_L;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      // The match test uses the post-step value, so a target already showing at
      // entry is only reached after a full revolution.
      ST_SLOW_L: begin
        if (tick) begin
          left_d  = left_next;
          right_d = right_next;
          if (left_next == tgt_l_q) begin
            cnt_d   = '0;
            state_d = ST_SLOW_R;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_SLOW_R: begin
        if (tick) begin
          right_d = right_next;
          if ((cnt_inc >= SLOW_R_MIN) && (right_next == tgt_r_q)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        match_d = (left_q == right_q);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      right_q <= '0;
      tgt_l_q <= '0;
      tgt_r_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      tgt_l_q <= tgt_l_d;
      tgt_r_q <= tgt_r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign sym_left     = left_q;
  assign sym_right    = right_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign result_match = match_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/reel_spin_sequencer.md
REEL_SPIN_SEQUENCER -- requirements
Module: reel_spin_sequencer

Interface
REQ-001 Parameter STEP_CYC, default 2500000: clk cycles per fast reel step (20 Hz at 50 MHz); must be at least 2.
REQ-002 Parameter MIN_STEPS, default 24: fast steps before the left reel starts stopping; must be at least 1.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: spin request; sampled only in IDLE.
REQ-006 Port seed, input, 16: random value; latched on an accepted start.
REQ-007 Port cheat_mode, input, 1: forced-match request; latched on an accepted start.
REQ-008 Port sym_left, output, 3: left reel symbol index.
REQ-009 Port sym_right, output, 3: right reel symbol index.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse when both reels have stopped.
REQ-012 Port result_match, output, 1: sym_left equals sym_right; valid while done is high, held until the next accepted start.

Function
REQ-013 The state machine SHALL have states IDLE, FAST, SLOW_L, SLOW_R and DONE.
REQ-014 IDLE with start=1: latch target_L=seed[2:0] and target_R=seed[5:3]; clear the step timer and step count; go to FAST.
REQ-015 A step SHALL occur every STEP_CYC cycles in FAST and every 2*STEP_CYC cycles in SLOW_L/SLOW_R, timed from state entry.
REQ-016 Each step SHALL increment the moving reels modulo 8 (7 wraps to 0).
REQ-017 FAST: both reels step; after MIN_STEPS steps, go to SLOW_L.
REQ-018 SLOW_L: both reels step; on the first step whose new sym_left equals target_L, the left reel freezes and the state goes to SLOW_R.
REQ-019 SLOW_L always takes at least 1 step; a target equal to sym_left at entry costs 8 steps.
REQ-020 SLOW_R: only the right reel steps; it freezes on the first step where the SLOW_R step count is at least 8 and the new sym_right equals target_R; the state then goes to DONE.
REQ-021 DONE: assert done for exactly 1 cycle, register result_match, return to IDLE.
REQ-022 start is ignored while busy is high; seed and cheat_mode changes after acceptance have no effect.
REQ-023 Reels start each spin from their last stopped values.
REQ-024 Step count width SHALL be the greater of clog2(MIN_STEPS+1) and 4 bits; the timer width SHALL be clog2(2*STEP_CYC) bits; there is no overflow.

Reset
REQ-025 rst=1 SHALL force state=IDLE, sym_left=0, sym_right=0, busy=0, done=0 and result_match=0, and clear the timer, count and targets.
REQ-026 rst SHALL take priority over start.
REQ-027 rst mid-spin SHALL abort the spin with no done pulse.

Configuration
REQ-028 With CHEAT_MODE_EN defined, a latched cheat_mode=1 SHALL set target_R=target_L.
REQ-029 Without CHEAT_MODE_EN, cheat_mode is ignored; the port remains present and no cheat logic is synthesised.

Structure
REQ-030 Package slot_pkg SHALL hold the N_SYMBOLS=8 and SYM_W=3 constants and the sequencer state enum.
REQ-031 One sub-module, step_timer, SHALL provide the period counter with a programmable fast/slow period and a one-cycle tick output.

Verification (STEP_CYC=4, MIN_STEPS=8, reels at 0, done cycle counted from the start-accept edge)
REQ-032 seed=16'h001A, cheat_mode=0: the sequence is 8 fast steps, 2 SLOW_L steps (left stops at 2), then 9 SLOW_R steps. Response: sym_left=2, sym_right=3, result_match=0, done at cycle 121.
REQ-033 The same seed with cheat_mode=1 and CHEAT_MODE_EN defined: sym_left=2, sym_right=2 after 8 SLOW_R steps, result_match=1, done at cycle 113. Without the macro, the result SHALL equal REQ-032.
REQ-034 seed=16'h0000 from reels at 0: SLOW_L takes 8 steps; both reels end at 0; result_match=1. Check the 7->0 wrap on every step.
REQ-035 start pulsed at cycles 5 and 50 during a spin, and seed changed mid-spin: there is no restart, and the result is identical to the undisturbed run.
REQ-036 rst asserted at cycle 40 of a spin: the next cycle shows IDLE, all outputs 0 and no done pulse. A following start spins normally.
